// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer.
// Holds the FSM state type and the branch-type codes.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] BR_JMP  = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JMP2 = 3'd7;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Combinational branch resolution from branch type and ALU flags.
// Kept standalone so a pipelined front end can reuse it.
module branch_cond
  import pc_sequencer_pkg::*;
(
  input  logic       is_branch,
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       neg,
  input  logic       ltu,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    if (is_branch) begin
      unique case (br_type)
        BR_JMP,
        BR_JMP2: cond = 1'b1;
        BR_BEQ:  cond = zero;
        BR_BNE:  cond = !zero;
        BR_BLT:  cond = neg;
        BR_BGE:  cond = !neg;
        BR_BLTU: cond = ltu;
        BR_BGEU: cond = !ltu;
        default: cond = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/exec sequencer owning the PC.
// Commits PC+1 or PC+imed when the datapath signals done.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            is_branch,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] imed,
  input  logic            zero,
  input  logic            neg,
  input  logic            ltu,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic            taken,
  output logic            halted,
  output logic [XLEN-1:0] instret
);

  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nx;
  logic            cond;
  logic            commit;
  logic [XLEN-1:0] next_pc;

  branch_cond u_cond (
    .is_branch (is_branch),
    .br_type   (br_type),
    .zero      (zero),
    .neg       (neg),
    .ltu       (ltu),
    .cond      (cond)
  );

  assign commit  = (state == ST_EXEC) && exec_done;
  assign next_pc = cond ? pc + imed : pc + ONE;

  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      ST_IDLE:   state_nx = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        instr_valid = 1'b1;
        state_nx    = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) state_nx = halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT:   halted = 1'b1;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      taken   <= 1'b0;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (commit) begin
        pc      <= next_pc;
        taken   <= cond;
        instret <= instret + ONE;
      end
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenario bench for pc_sequencer.
// Each task drives one feature and checks against hand-computed values.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        exec_done;
  logic        is_branch;
  logic [2:0]  br_type;
  logic [31:0] imed;
  logic        zero;
  logic        neg;
  logic        ltu;
  logic        halt;
  logic [31:0] pc;
  logic        taken;
  logic        halted;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .is_branch   (is_branch),
    .br_type     (br_type),
    .imed        (imed),
    .zero        (zero),
    .neg         (neg),
    .ltu         (ltu),
    .halt        (halt),
    .pc          (pc),
    .taken       (taken),
    .halted      (halted),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    is_branch = 1'b0;
    br_type   = 3'd0;
    imed      = 32'h0;
    zero      = 1'b0;
    neg       = 1'b0;
    ltu       = 1'b0;
    halt      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fetch one instruction and execute it with the given operands.
  task automatic run_instr(input logic ib, input logic [2:0] bt,
                           input logic [31:0] im, input logic z,
                           input logic n, input logic l, input logic h);
    int k;
    k = 0;
    while (!imem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!imem_req) begin
      errors++;
      $display("FAIL fetch_timeout req=%b required=1", imem_req);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL decode_pulse instr_valid=%b required=1", instr_valid);
    end
    @(negedge clk);
    exec_done = 1'b1;
    is_branch = ib;
    br_type   = bt;
    imed      = im;
    zero      = z;
    neg       = n;
    ltu       = l;
    halt      = h;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic check_pc(input string name, input logic [31:0] epc,
                          input logic etk);
    checks++;
    if (pc !== epc || taken !== etk) begin
      errors++;
      $display("FAIL %s pc=%h taken=%b required pc=%h taken=%b",
               name, pc, taken, epc, etk);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (pc !== 32'h0 || taken !== 1'b0 || instret !== 32'h0 ||
        imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h tk=%b ir=%h req=%b iv=%b hl=%b required all 0",
               pc, taken, instret, imem_req, instr_valid, halted);
    end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    rst_n     = 1'b1;
    imem_ack  = 1'b1;
    exec_done = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 1 || e == 4 || e == 7) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'((e - 1) / 3)) begin
          errors++;
          $display("FAIL seq_fetch edge%0d req=%b addr=%h required req=1 addr=%h",
                   e, imem_req, imem_addr, 32'((e - 1) / 3));
        end
      end
    end
    checks++;
    if (instret !== 32'd3 || pc !== 32'd3) begin
      errors++;
      $display("FAIL seq_instret instret=%0d pc=%0d required 3 3", instret, pc);
    end
    clear_inputs();
  endtask

  task automatic test_beq();
    do_reset();
    run_instr(1'b1, 3'd0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc("jump_to_8", 32'd8, 1'b1);
    run_instr(1'b1, 3'd1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    check_pc("beq_taken", 32'd4, 1'b1);
    run_instr(1'b1, 3'd7, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc("jump7_to_8", 32'd8, 1'b1);
    run_instr(1'b1, 3'd1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc("beq_not_taken", 32'd9, 1'b0);
    run_instr(1'b1, 3'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc("bne_taken", 32'd12, 1'b1);
    run_instr(1'b1, 3'd3, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    check_pc("blt_not_taken", 32'd13, 1'b0);
    run_instr(1'b0, 3'd0, 32'd50, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pc("non_branch", 32'd14, 1'b0);
    checks++;
    if (instret !== 32'd7) begin
      errors++;
      $display("FAIL beq_instret instret=%0d required 7", instret);
    end
  endtask

  task automatic test_unsigned();
    do_reset();
    run_instr(1'b1, 3'd5, 32'd16, 1'b0, 1'b0, 1'b1, 1'b0);
    check_pc("bltu_taken", 32'd16, 1'b1);
    do_reset();
    run_instr(1'b1, 3'd6, 32'd16, 1'b0, 1'b0, 1'b1, 1'b0);
    check_pc("bgeu_not_taken", 32'd1, 1'b0);
    run_instr(1'b1, 3'd4, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_pc("bge_equal_taken", 32'd6, 1'b1);
  endtask

  task automatic test_stall();
    int pulses;
    logic bad;
    do_reset();
    @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold req=%b iv=%b required req=1 iv=0",
               imem_req, instr_valid);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (instr_valid) pulses++;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL stall_pulse count=%0d required 1", pulses);
    end
    checks++;
    if (pc !== 32'd0 || instret !== 32'd0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL exec_ignores_ack pc=%h ir=%0d req=%b required 0 0 0",
               pc, instret, imem_req);
    end
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    check_pc("stall_commit", 32'd1, 1'b0);
  endtask

  task automatic test_halt();
    logic bad;
    do_reset();
    run_instr(1'b1, 3'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pc("halt_pc", 32'd4, 1'b0);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_flag halted=%b required 1", halted);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_ack  = i[0];
      exec_done = ~i[0];
      is_branch = 1'b1;
      imed      = 32'd7;
      @(negedge clk);
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1)
        bad = 1'b1;
    end
    clear_inputs();
    checks++;
    if (bad || pc !== 32'd4 || instret !== 32'd2) begin
      errors++;
      $display("FAIL halt_sticky bad=%b pc=%h ir=%0d required 0 4 2",
               bad, pc, instret);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run_instr(1'b1, 3'd0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      errors++;
      $display("FAIL pre_reset_fetch req=%b addr=%h required 1 20",
               imem_req, imem_addr);
    end
    #2;
    imem_ack = 1'b1;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b0 || instret !== 32'h0) begin
      errors++;
      $display("FAIL async_reset pc=%h req=%b ir=%h required 0 0 0",
               pc, imem_req, instret);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL refetch req=%b addr=%h required 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc("jump_to_max", 32'hFFFF_FFFF, 1'b1);
    run_instr(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc("pc_wrap", 32'h0, 1'b0);
    run_instr(1'b1, 3'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_pc("self_loop", 32'h0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_unsigned();
    test_stall();
    test_halt();
    test_reset_mid_fetch();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
